// File: rtl/seq_control_n_pkg.sv
// Shared types and default sizing for the step sequencer control block.
package seq_pkg;

  localparam int NUM_CH_DEF = 4;
  localparam int STEPS_DEF  = 8;
  localparam int PER_W_DEF  = 24;

  typedef enum logic [2:0] {
    S_LOAD_PER      = 3'd0,
    S_LOAD_PER_WAIT = 3'd1,
    S_LOAD_CH       = 3'd2,
    S_LOAD_CH_WAIT  = 3'd3,
    S_PLAY          = 3'd4,
    S_PAUSE         = 3'd5
  } state_t;

endpackage

// File: rtl/seq_control_n_step_timer.sv
// Tempo divider and step counter; step, step_tick and bar_start are registered.
module seq_step_timer #(
  parameter int STEPS  = 8,
  parameter int STEP_W = $clog2(STEPS),
  parameter int PER_W  = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic              i_run,
  input  logic              i_clear,
  input  logic [PER_W-1:0]  i_period,
  output logic [STEP_W-1:0] o_step,
  output logic              o_step_tick,
  output logic              o_bar_start
);

  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEPS - 1);

  logic [PER_W-1:0]  r_div;
  logic [STEP_W-1:0] r_step;
  logic              r_tick;
  logic              r_bar;
  logic [STEP_W-1:0] w_step_nxt;
  logic              w_div_last;

  assign w_step_nxt = (r_step == STEP_LAST) ? '0 : r_step + 1'b1;
  assign w_div_last = (r_div == i_period - PER_W'(1));

  always_ff @(posedge clk) begin
    if (!reset || i_clear) begin
      r_div  <= '0;
      r_step <= '0;
      r_tick <= 1'b0;
      r_bar  <= 1'b0;
    end else if (i_start) begin
      r_div  <= '0;
      r_step <= '0;
      r_tick <= 1'b1;
      r_bar  <= 1'b1;
    end else if (i_run && w_div_last) begin
      r_div  <= '0;
      r_step <= w_step_nxt;
      r_tick <= 1'b1;
      r_bar  <= (w_step_nxt == '0);
    end else begin
      // Paused or mid-period: div advances only while running, tick is a single pulse.
      if (i_run) r_div <= r_div + 1'b1;
      r_tick <= 1'b0;
      r_bar  <= 1'b0;
    end
  end

  assign o_step      = r_step;
  assign o_step_tick = r_tick;
  assign o_bar_start = r_bar;

endmodule

// File: rtl/seq_control_n.sv
// Step sequencer control: load handshake for period and channel patterns, then
// endless playback with pause/stop.
//   state           | meaning
//   S_LOAD_PER      | wait for go, capture period from data_in
//   S_LOAD_PER_WAIT | wait for go release
//   S_LOAD_CH       | ld_ch[ch_idx] high, wait for go
//   S_LOAD_CH_WAIT  | wait for go release, then next channel or play
//   S_PLAY          | timer running
//   S_PAUSE         | timer frozen
module seq_control_n
  import seq_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int STEPS  = STEPS_DEF,
  parameter int STEP_W = $clog2(STEPS),
  parameter int PER_W  = PER_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_go,
  input  logic              i_pause,
  input  logic              i_stop,
  input  logic [PER_W-1:0]  i_data_in,
  output logic              o_ld_period,
  output logic [NUM_CH-1:0] o_ld_ch,
  output logic              o_playing,
  output logic              o_paused,
  output logic [STEP_W-1:0] o_step,
  output logic              o_step_tick,
  output logic              o_bar_start
);

  localparam int              CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CH_W-1:0] CH_LAST = CH_W'(NUM_CH - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CH_W-1:0]  r_ch_idx;
  logic [PER_W-1:0] r_period;
  logic             w_start;
  logic             w_run;
  logic             w_clear;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= S_LOAD_PER;
      r_ch_idx <= '0;
      r_period <= PER_W'(1);
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_LOAD_PER && i_go)
        r_period <= (i_data_in == '0) ? PER_W'(1) : i_data_in;
      if (w_clear)
        r_ch_idx <= '0;
      else if (r_state == S_LOAD_CH_WAIT && !i_go)
        r_ch_idx <= (r_ch_idx == CH_LAST) ? '0 : r_ch_idx + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_ld_period = 1'b0;
    o_ld_ch     = '0;
    o_playing   = 1'b0;
    o_paused    = 1'b0;
    w_start     = 1'b0;
    w_run       = 1'b0;
    w_clear     = 1'b0;
    case (r_state)
      S_LOAD_PER: begin
        o_ld_period = 1'b1;
        if (i_go) w_state_nxt = S_LOAD_PER_WAIT;
      end
      S_LOAD_PER_WAIT: begin
        if (!i_go) w_state_nxt = S_LOAD_CH;
      end
      S_LOAD_CH: begin
        o_ld_ch = NUM_CH'(1) << r_ch_idx;
        if (i_go) w_state_nxt = S_LOAD_CH_WAIT;
      end
      S_LOAD_CH_WAIT: begin
        if (!i_go) begin
          if (r_ch_idx == CH_LAST) begin
            w_state_nxt = S_PLAY;
            w_start     = 1'b1;
          end else begin
            w_state_nxt = S_LOAD_CH;
          end
        end
      end
      S_PLAY: begin
        o_playing = 1'b1;
        // Stop beats pause, and pause beats a tick due this cycle.
        if (i_stop) begin
          w_state_nxt = S_LOAD_PER;
          w_clear     = 1'b1;
        end else if (i_pause) begin
          w_state_nxt = S_PAUSE;
        end else begin
          w_run = 1'b1;
        end
      end
      S_PAUSE: begin
        o_playing = 1'b1;
        o_paused  = 1'b1;
        if (i_stop) begin
          w_state_nxt = S_LOAD_PER;
          w_clear     = 1'b1;
        end else if (!i_pause) begin
          w_state_nxt = S_PLAY;
        end
      end
      default: w_state_nxt = S_LOAD_PER;
    endcase
  end

  seq_step_timer #(
    .STEPS  (STEPS),
    .STEP_W (STEP_W),
    .PER_W  (PER_W)
  ) u_timer (
    .clk         (clk),
    .reset       (reset),
    .i_start     (w_start),
    .i_run       (w_run),
    .i_clear     (w_clear),
    .i_period    (r_period),
    .o_step      (o_step),
    .o_step_tick (o_step_tick),
    .o_bar_start (o_bar_start)
  );

endmodule

// File: tb/tb_seq_control_n.sv
// Directed bench for seq_control_n: default build plus a STEPS=5 build sharing inputs.
module tb_seq_control_n;

  logic        clk = 1'b0;
  logic        reset;
  logic        go, pause, stop;
  logic [23:0] data_in;

  logic        ld_period, playing, paused, step_tick, bar_start;
  logic [3:0]  ld_ch;
  logic [2:0]  step;

  logic        ld_period5, playing5, paused5, step_tick5, bar_start5;
  logic [3:0]  ld_ch5;
  logic [2:0]  step5;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  seq_control_n dut (
    .clk(clk), .reset(reset), .i_go(go), .i_pause(pause), .i_stop(stop),
    .i_data_in(data_in), .o_ld_period(ld_period), .o_ld_ch(ld_ch),
    .o_playing(playing), .o_paused(paused), .o_step(step),
    .o_step_tick(step_tick), .o_bar_start(bar_start)
  );

  seq_control_n #(.STEPS(5)) dut5 (
    .clk(clk), .reset(reset), .i_go(go), .i_pause(pause), .i_stop(stop),
    .i_data_in(data_in), .o_ld_period(ld_period5), .o_ld_ch(ld_ch5),
    .o_playing(playing5), .o_paused(paused5), .o_step(step5),
    .o_step_tick(step_tick5), .o_bar_start(bar_start5)
  );

  task automatic step_clk(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Walks period + 4 channel loads; returns at the first play cycle.
  task automatic load_all(input logic [23:0] per);
    data_in = per;
    chk("load ld_period", {31'd0, ld_period}, 1);
    go = 1'b1;
    step_clk(1);
    chk("per_wait ld_period", {31'd0, ld_period}, 0);
    step_clk(1);
    go = 1'b0;
    step_clk(1);
    for (int c = 0; c < 4; c++) begin
      chk("ld_ch", {28'd0, ld_ch}, 32'd1 << c);
      chk("load playing", {31'd0, playing}, 0);
      go = 1'b1;
      step_clk(2);
      chk("ch_wait ld_ch", {28'd0, ld_ch}, 0);
      go = 1'b0;
      step_clk(1);
    end
    chk("entry playing", {31'd0, playing}, 1);
    chk("entry step", {29'd0, step}, 0);
    chk("entry tick", {31'd0, step_tick}, 1);
    chk("entry bar", {31'd0, bar_start}, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; go = 1'b0; pause = 1'b0; stop = 1'b0; data_in = '0;
    step_clk(2);
    chk("rst ld_period", {31'd0, ld_period}, 1);
    chk("rst ld_ch", {28'd0, ld_ch}, 0);
    chk("rst playing", {31'd0, playing}, 0);
    chk("rst paused", {31'd0, paused}, 0);
    chk("rst tick", {31'd0, step_tick}, 0);
    chk("rst bar", {31'd0, bar_start}, 0);
    reset = 1'b1;
    step_clk(1);

    // Period 3: ticks every 3 play cycles, wrap at cycle 24.
    load_all(24'd3);
    for (int k = 1; k <= 24; k++) begin
      step_clk(1);
      chk("p3 tick", {31'd0, step_tick}, (k % 3 == 0) ? 1 : 0);
      chk("p3 step", {29'd0, step}, (k / 3) % 8);
      chk("p3 bar", {31'd0, bar_start}, (k % 24 == 0) ? 1 : 0);
    end

    stop = 1'b1;
    step_clk(1);
    stop = 1'b0;
    chk("stop playing", {31'd0, playing}, 0);
    chk("stop ld_period", {31'd0, ld_period}, 1);
    chk("stop step", {29'd0, step}, 0);

    // Period 4, pause two cycles into step 5 for ten cycles.
    load_all(24'd4);
    step_clk(20);
    chk("p4 step5 tick", {31'd0, step_tick}, 1);
    chk("p4 step5", {29'd0, step}, 5);
    step_clk(2);
    pause = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step_clk(1);
      chk("pause paused", {31'd0, paused}, 1);
      chk("pause step", {29'd0, step}, 5);
      chk("pause tick", {31'd0, step_tick}, 0);
    end
    pause = 1'b0;
    step_clk(1);
    chk("resume paused", {31'd0, paused}, 0);
    chk("resume playing", {31'd0, playing}, 1);
    chk("resume tick0", {31'd0, step_tick}, 0);
    step_clk(1);
    chk("resume tick1", {31'd0, step_tick}, 0);
    step_clk(1);
    chk("resume tick2", {31'd0, step_tick}, 1);
    chk("resume step", {29'd0, step}, 6);

    // Stop while paused, stop wins over a held pause.
    pause = 1'b1;
    step_clk(1);
    chk("pause2 paused", {31'd0, paused}, 1);
    stop = 1'b1;
    step_clk(1);
    stop = 1'b0;
    pause = 1'b0;
    chk("pstop ld_period", {31'd0, ld_period}, 1);
    chk("pstop playing", {31'd0, playing}, 0);
    chk("pstop paused", {31'd0, paused}, 0);
    chk("pstop step", {29'd0, step}, 0);

    load_all(24'd4);
    step_clk(1);
    chk("replay tick1", {31'd0, step_tick}, 0);
    step_clk(3);
    chk("replay tick4", {31'd0, step_tick}, 1);
    chk("replay step", {29'd0, step}, 1);

    reset = 1'b0;
    step_clk(1);
    chk("midrst ld_period", {31'd0, ld_period}, 1);
    chk("midrst ld_ch", {28'd0, ld_ch}, 0);
    chk("midrst playing", {31'd0, playing}, 0);
    chk("midrst step", {29'd0, step}, 0);
    chk("midrst tick", {31'd0, step_tick}, 0);
    chk("midrst bar", {31'd0, bar_start}, 0);
    reset = 1'b1;
    step_clk(1);

    // Zero period behaves as 1: one step per cycle, both builds.
    load_all(24'd0);
    for (int k = 1; k <= 12; k++) begin
      step_clk(1);
      chk("z tick", {31'd0, step_tick}, 1);
      chk("z step", {29'd0, step}, k % 8);
      chk("z bar", {31'd0, bar_start}, (k % 8 == 0) ? 1 : 0);
      chk("z5 tick", {31'd0, step_tick5}, 1);
      chk("z5 step", {29'd0, step5}, k % 5);
      chk("z5 bar", {31'd0, bar_start5}, (k % 5 == 0) ? 1 : 0);
    end

    // Held go in S_LOAD_CH(1): exactly one advance.
    stop = 1'b1;
    step_clk(1);
    stop = 1'b0;
    data_in = 24'd2;
    go = 1'b1;
    step_clk(2);
    go = 1'b0;
    step_clk(1);
    chk("held ch0", {28'd0, ld_ch}, 1);
    go = 1'b1;
    step_clk(2);
    go = 1'b0;
    step_clk(1);
    chk("held ch1", {28'd0, ld_ch}, 2);
    go = 1'b1;
    for (int k = 0; k < 50; k++) begin
      step_clk(1);
      chk("held wait ld_ch", {28'd0, ld_ch}, 0);
    end
    go = 1'b0;
    step_clk(1);
    chk("held ch2", {28'd0, ld_ch}, 4);

    // stop/pause are ignored during loading.
    stop = 1'b1;
    pause = 1'b1;
    step_clk(1);
    chk("load ignore ld_ch", {28'd0, ld_ch}, 4);
    chk("load ignore playing", {31'd0, playing}, 0);
    stop = 1'b0;
    pause = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
